// File: rtl/router_pkg.sv
// Shared types and helpers for the lookahead router input stage.
// Holds the direction encoding, the flit layout and the XY next-hop computation.
package router_pkg;

    localparam int COORD_W   = 3;
    localparam int PAYLOAD_W = 32;
    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        N = 3'd0,
        S = 3'd1,
        W = 3'd2,
        E = 3'd3,
        L = 3'd4
    } dir_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic                 head;
        logic                 tail;
        dir_t                 route;
        logic [COORD_W-1:0]   dst_x;
        logic [COORD_W-1:0]   dst_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    // Codes 5-7 carry no direction and are folded onto the local port.
    function automatic dir_t norm_dir(input logic [2:0] code);
        dir_t d;
        case (code)
            3'd0:    d = N;
            3'd1:    d = S;
            3'd2:    d = W;
            3'd3:    d = E;
            default: d = L;
        endcase
        return d;
    endfunction

    function automatic dir_t next_route_xy(
        input dir_t               dir,
        input logic [COORD_W-1:0] lx,
        input logic [COORD_W-1:0] ly,
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy
    );
        logic [COORD_W-1:0] nx;
        logic [COORD_W-1:0] ny;
        dir_t               nxt;
        nx = lx;
        ny = ly;
        case (dir)
            N:       ny = ly - COORD_W'(1);
            S:       ny = ly + COORD_W'(1);
            W:       nx = lx - COORD_W'(1);
            E:       nx = lx + COORD_W'(1);
            default: begin
                nx = lx;
                ny = ly;
            end
        endcase
        if (dir == L)       nxt = L;
        else if (dx > nx)   nxt = E;
        else if (dx < nx)   nxt = W;
        else if (dy > ny)   nxt = S;
        else if (dy < ny)   nxt = N;
        else                nxt = L;
        return nxt;
    endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// Flit FIFO with wrap-bit pointers; a full FIFO refuses pushes even when popping.
// Push/pop requests are masked internally against full/empty.
module router_flit_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  flit_t wdata_i,
    input  logic  pop_i,
    output flit_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int AW = $clog2(DEPTH);

    flit_t         mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          push_s;
    logic          pop_s;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/router_input_unit.sv
// Input port of the lookahead router: buffers flits, holds a one-hot output request per packet,
// pops on grant and rewrites the lookahead route field of forwarded head flits.
module router_input_unit
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] local_x,
    input  logic [COORD_W-1:0] local_y,
    input  flit_t              in_flit,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4:0]         request,
    input  logic [4:0]         grant,
    input  logic [4:0]         out_ready,
    output flit_t              out_flit,
    output logic               forwarding_head,
    output logic               forwarding_tail,
    output logic               err_orphan
);

    state_t     state_q;
    dir_t       dir_q;
    flit_t      front_s;
    logic       full_s;
    logic       empty_s;
    logic       pop_s;
    logic       fire_s;
    logic       orphan_s;
    logic [4:0] req_s;
    dir_t       front_dir_s;
    dir_t       cur_dir_s;
    flit_t      out_flit_s;

    router_flit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .wdata_i (in_flit),
        .pop_i   (pop_s),
        .rdata_o (front_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // request, fire and orphan-drop decode for the current front flit
    always_comb begin
        front_dir_s = norm_dir(front_s.route);
        req_s       = 5'b00000;
        orphan_s    = 1'b0;
        if (state_q == ST_ACTIVE) begin
            cur_dir_s = dir_q;
            req_s     = 5'b00001 << dir_q;
        end else begin
            cur_dir_s = front_dir_s;
            if (!empty_s && front_s.head) begin
                req_s = 5'b00001 << front_dir_s;
            end else if (!empty_s) begin
                orphan_s = 1'b1;
            end else begin
                req_s = 5'b00000;
            end
        end
        fire_s = !empty_s && req_s[cur_dir_s] && grant[cur_dir_s] && out_ready[cur_dir_s];
        pop_s  = fire_s || orphan_s;
    end

    // A head seen while a packet is open is passed through as a body flit.
    always_comb begin
        out_flit_s = front_s;
        if ((state_q == ST_IDLE) && front_s.head) begin
            out_flit_s.route = next_route_xy(front_dir_s, local_x, local_y,
                                             front_s.dst_x, front_s.dst_y);
        end else begin
            out_flit_s.route = front_s.route;
        end
    end

    assign in_ready        = !full_s;
    assign request         = req_s;
    assign out_flit        = out_flit_s;
    assign forwarding_head = fire_s && front_s.head && (state_q == ST_IDLE);
    assign forwarding_tail = fire_s && front_s.tail;
    assign err_orphan      = orphan_s;

    // packet state: open on a non-tail head fire, close on tail fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= L;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire_s && !front_s.tail) begin
                        state_q <= ST_ACTIVE;
                        dir_q   <= front_dir_s;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (fire_s && front_s.tail) state_q <= ST_IDLE;
                    else                        state_q <= ST_ACTIVE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit with a queue-based reference model checked every cycle.
module tb_router_input_unit;
    import router_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   local_x;
    logic [2:0]   local_y;
    flit_t        in_flit;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   request;
    logic [4:0]   grant;
    logic [4:0]   out_ready;
    flit_t        out_flit;
    logic         forwarding_head;
    logic         forwarding_tail;
    logic         err_orphan;

    int total = 0;
    int bad   = 0;

    router_input_unit #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .local_x         (local_x),
        .local_y         (local_y),
        .in_flit         (in_flit),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .request         (request),
        .grant           (grant),
        .out_ready       (out_ready),
        .out_flit        (out_flit),
        .forwarding_head (forwarding_head),
        .forwarding_tail (forwarding_tail),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic flit_t mk(input bit h, input bit t, input logic [2:0] r,
                                 input logic [2:0] dx, input logic [2:0] dy, input logic [31:0] p);
        flit_t f;
        f.head    = h;
        f.tail    = t;
        f.route   = dir_t'(r);
        f.dst_x   = dx;
        f.dst_y   = dy;
        f.payload = p;
        return f;
    endfunction

    // ---------------- reference model ----------------
    flit_t mq[$];
    bit    m_active;
    int    m_dir;
    bit    d_push, d_pop, d_go_active, d_go_idle;
    int    d_dir;
    flit_t d_flit;

    logic [4:0] e_req;
    bit         e_fire, e_err, e_h, e_t;
    flit_t      e_out;
    int         e_d;

    function automatic int ndir(input logic [2:0] c);
        return (c > 3'd4) ? 4 : int'(c);
    endfunction

    // Directions as integers: N=0 S=1 W=2 E=3 L=4
    function automatic logic [2:0] exp_next(input int d, input int lx, input int ly,
                                            input int dx, input int dy);
        int nx, ny;
        if (d == 4) return 3'd4;
        nx = lx + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
        ny = ly + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
        nx = (nx + 8) % 8;
        ny = (ny + 8) % 8;
        if (dx > nx) return 3'd3;
        if (dx < nx) return 3'd2;
        if (dy > ny) return 3'd1;
        if (dy < ny) return 3'd0;
        return 3'd4;
    endfunction

    always @(negedge clk) begin
        d_push = 0; d_pop = 0; d_go_active = 0; d_go_idle = 0; d_dir = 4;
        if (rst_n) begin
            e_req = 5'b00000; e_fire = 0; e_err = 0; e_h = 0; e_t = 0; e_d = 4;
            if (m_active) begin
                e_d   = m_dir;
                e_req = 5'(1 << m_dir);
            end
            if (mq.size() > 0) begin
                e_out = mq[0];
                if (m_active) begin
                    e_fire = grant[e_d] && out_ready[e_d];
                end else if (mq[0].head) begin
                    e_d    = ndir(mq[0].route);
                    e_req  = 5'(1 << e_d);
                    e_fire = grant[e_d] && out_ready[e_d];
                    e_out.route = dir_t'(exp_next(e_d, int'(local_x), int'(local_y),
                                                  int'(mq[0].dst_x), int'(mq[0].dst_y)));
                end else begin
                    e_err = 1;
                end
                e_h = e_fire && mq[0].head && !m_active;
                e_t = e_fire && mq[0].tail;
                d_go_active = e_fire && !m_active && !mq[0].tail;
                d_go_idle   = e_fire && m_active && mq[0].tail;
                check("out_flit", 64'(out_flit), 64'(e_out));
            end
            check("request", 64'(request), 64'(e_req));
            check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            check("fwd_head", 64'(forwarding_head), 64'(e_h));
            check("fwd_tail", 64'(forwarding_tail), 64'(e_t));
            check("err_orphan", 64'(err_orphan), 64'(e_err));
            d_push = in_valid && (mq.size() < DEPTH);
            d_flit = in_flit;
            d_pop  = e_fire || e_err;
            d_dir  = e_d;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_active <= 1'b0;
            m_dir    <= 4;
        end else begin
            if (d_pop)  void'(mq.pop_front());
            if (d_push) mq.push_back(d_flit);
            if (d_go_active) begin
                m_active <= 1'b1;
                m_dir    <= d_dir;
            end
            if (d_go_idle) m_active <= 1'b0;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input flit_t f);
        in_valid = 1'b1;
        in_flit  = f;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0;
        grant = 5'b00000; out_ready = 5'b00000;
        local_x = 3'd1; local_y = 3'd1;
        tick(); tick();
        check("rst_request", 64'(request), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_fwd", 64'({forwarding_head, forwarding_tail, err_orphan}), 64'h0);
        rst_n = 1'b1;
        tick();

        // 3-flit packet east from (1,1) to (3,1)
        grant = 5'b01000; out_ready = 5'b01000;
        push(mk(1'b1, 1'b0, 3'd3, 3'd3, 3'd1, 32'hA000_0001));
        #1;
        check("p3_req_head", 64'(request), 64'h08);
        check("p3_fwd_head", 64'({forwarding_head, forwarding_tail}), 64'h2);
        check("p3_out_route", 64'(out_flit.route), 64'h3);
        push(mk(1'b0, 1'b0, 3'd3, 3'd3, 3'd1, 32'hA000_0002));
        #1;
        check("p3_req_body", 64'(request), 64'h08);
        check("p3_fwd_body", 64'({forwarding_head, forwarding_tail}), 64'h0);
        push(mk(1'b0, 1'b1, 3'd3, 3'd3, 3'd1, 32'hA000_0003));
        #1;
        check("p3_fwd_tail", 64'({forwarding_head, forwarding_tail}), 64'h1);
        tick(); #1;
        check("p3_req_done", 64'(request), 64'h0);

        // single-flit packet north from (2,2) to (2,0)
        local_x = 3'd2; local_y = 3'd2;
        grant = 5'b00001; out_ready = 5'b00001;
        push(mk(1'b1, 1'b1, 3'd0, 3'd2, 3'd0, 32'hB000_0001));
        #1;
        check("sf_req", 64'(request), 64'h01);
        check("sf_head_tail", 64'({forwarding_head, forwarding_tail}), 64'h3);
        check("sf_out_route", 64'(out_flit.route), 64'h0);
        tick(); #1;
        check("sf_idle_req", 64'(request), 64'h0);

        // fill without grants
        local_x = 3'd1; local_y = 3'd1;
        grant = 5'b00000; out_ready = 5'b00000;
        for (int i = 0; i < 4; i++) push(mk(1'b1, 1'b1, 3'd3, 3'd5, 3'd1, 32'hC000_0000 + 32'(i)));
        #1;
        check("fill_in_ready_0", 64'(in_ready), 64'h0);
        in_valid = 1'b1; in_flit = mk(1'b1, 1'b1, 3'd3, 3'd5, 3'd1, 32'hC000_00FF);
        tick();
        in_valid = 1'b0;
        check("fill_5th_blocked", 64'(in_ready), 64'h0);
        grant = 5'b01000; out_ready = 5'b01000;
        tick();
        grant = 5'b00000;
        #1;
        check("fill_in_ready_1", 64'(in_ready), 64'h1);
        grant = 5'b01000;
        repeat (3) tick();
        grant = 5'b00000;
        #1;
        check("fill_drained", 64'(request), 64'h0);

        // head fires, FIFO runs dry before the tail
        grant = 5'b01000; out_ready = 5'b01000;
        push(mk(1'b1, 1'b0, 3'd3, 3'd3, 3'd1, 32'hD000_0001));
        #1;
        check("gap_fwd_head", 64'(forwarding_head), 64'h1);
        tick(); #1;
        check("gap_req_1", 64'(request), 64'h08);
        tick(); #1;
        check("gap_req_2", 64'(request), 64'h08);
        push(mk(1'b0, 1'b1, 3'd3, 3'd3, 3'd1, 32'hD000_0002));
        #1;
        check("gap_fwd_tail", 64'(forwarding_tail), 64'h1);
        tick(); #1;
        check("gap_req_done", 64'(request), 64'h0);

        // orphan body flit in IDLE
        grant = 5'b00000; out_ready = 5'b00000;
        push(mk(1'b0, 1'b0, 3'd3, 3'd3, 3'd1, 32'hE000_0001));
        #1;
        check("orphan_err", 64'(err_orphan), 64'h1);
        check("orphan_req", 64'(request), 64'h0);
        tick(); #1;
        check("orphan_err_off", 64'(err_orphan), 64'h0);
        check("orphan_dropped", 64'(request), 64'h0);

        // illegal route code behaves as local
        grant = 5'b10000; out_ready = 5'b10000;
        push(mk(1'b1, 1'b1, 3'd6, 3'd1, 3'd1, 32'hE000_0002));
        #1;
        check("illegal_req", 64'(request), 64'h10);
        check("illegal_fwd", 64'({forwarding_head, forwarding_tail}), 64'h3);
        tick();

        // reset in the middle of a packet
        grant = 5'b01000; out_ready = 5'b01000;
        push(mk(1'b1, 1'b0, 3'd3, 3'd3, 3'd1, 32'hF000_0001));
        push(mk(1'b0, 1'b0, 3'd3, 3'd3, 3'd1, 32'hF000_0002));
        grant = 5'b00000;
        #1;
        check("mid_req_active", 64'(request), 64'h08);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(request), 64'h0);
        check("mid_rst_in_ready", 64'(in_ready), 64'h1);
        check("mid_rst_pulses", 64'({forwarding_head, forwarding_tail, err_orphan}), 64'h0);
        tick();
        rst_n = 1'b1;
        grant = 5'b10000; out_ready = 5'b10000;
        push(mk(1'b1, 1'b1, 3'd4, 3'd1, 3'd1, 32'hF000_0003));
        #1;
        check("post_rst_req", 64'(request), 64'h10);
        check("post_rst_route", 64'(out_flit.route), 64'h4);
        check("post_rst_fwd", 64'({forwarding_head, forwarding_tail}), 64'h3);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
